hpdmc_arb: RTL and testbench

HPDMC_ARB -- requirements
Module: hpdmc_arb

---
 rtl/hpdmc_arb.sv | 122 ++++++++++++
 tb/tb_hpdmc_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdmc_arb.sv
// Round-robin arbiter sharing one HPDMC WISHBONE slave port among NPORTS masters.
// Grants are released voluntarily or preempted at transfer boundaries after MAXBURST acks.
module hpdmc_arb #(
  parameter int unsigned NPORTS   = 4,
  parameter int unsigned DW       = 64,
  parameter int unsigned MAXBURST = 4
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [NPORTS*32-1:0]       m_adr_i,
  input  logic [NPORTS*3-1:0]        m_cti_i,
  input  logic [NPORTS*DW-1:0]       m_dat_i,
  input  logic [NPORTS*(DW/8)-1:0]   m_sel_i,
  input  logic [NPORTS-1:0]          m_cyc_i,
  input  logic [NPORTS-1:0]          m_stb_i,
  input  logic [NPORTS-1:0]          m_we_i,
  output logic [DW-1:0]              m_dat_o,
  output logic [NPORTS-1:0]          m_ack_o,
  output logic [31:0]                s_adr_o,
  output logic [2:0]                 s_cti_o,
  output logic [DW-1:0]              s_dat_o,
  output logic [DW/8-1:0]            s_sel_o,
  output logic                       s_cyc_o,
  output logic                       s_stb_o,
  output logic                       s_we_o,
  input  logic [DW-1:0]              s_dat_i,
  input  logic                       s_ack_i,
  output logic [NPORTS-1:0]          grant_o
);

  localparam int unsigned IW     = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int unsigned SW     = DW / 8;
  localparam logic [7:0]  MaxCnt = 8'(MAXBURST);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e            state_q, state_d;
  logic [NPORTS-1:0] grant_q, grant_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic [7:0]        cnt_ack;
  logic              in_grant;
  logic              others_req;
  logic              at_boundary;

  // Scan from the farthest offset down so the nearest requester at or after ptr_q wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (m_cyc_i[(int'(ptr_q) + i) % NPORTS]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'((int'(ptr_q) + i) % NPORTS);
      end
    end
  end

  assign in_grant    = (state_q == StGrant);
  assign s_adr_o     = m_adr_i[idx_q*32 +: 32];
  assign s_cti_o     = m_cti_i[idx_q*3 +: 3];
  assign s_dat_o     = m_dat_i[idx_q*DW +: DW];
  assign s_sel_o     = m_sel_i[idx_q*SW +: SW];
  assign s_we_o      = m_we_i[idx_q];
  assign s_cyc_o     = in_grant & m_cyc_i[idx_q];
  assign s_stb_o     = in_grant & m_stb_i[idx_q];
  assign m_dat_o     = s_dat_i;
  assign m_ack_o     = grant_q & {NPORTS{s_ack_i}};
  assign grant_o     = grant_q;

  assign cnt_ack     = (cnt_q >= MaxCnt) ? cnt_q : cnt_q + 8'd1;
  assign others_req  = |(m_cyc_i & ~grant_q);
  // Only classic cycles and end-of-burst acks are safe points to hand the bus over.
  assign at_boundary = (s_cti_o == 3'b000) || (s_cti_o == 3'b111);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StGrant;
          idx_d   = pick_idx;
          grant_d = NPORTS'(1) << pick_idx;
          cnt_d   = '0;
        end
      end
      StGrant: begin
        if (s_ack_i) cnt_d = cnt_ack;
        if (!m_cyc_i[idx_q] ||
            (s_ack_i && (cnt_ack >= MaxCnt) && at_boundary && others_req)) begin
          state_d = StIdle;
          grant_d = '0;
          ptr_d   = (idx_q == IW'(NPORTS - 1)) ? '0 : idx_q + IW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hpdmc_arb.sv
// Bench for hpdmc_arb: directed scenarios plus random traffic against a
// cycle-level behavioural model of the round-robin/preemption rules.
module tb_hpdmc_arb;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int MB = 4;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [N*32-1:0]   m_adr;
  logic [N*3-1:0]    m_cti;
  logic [N*DW-1:0]   m_dat;
  logic [N*8-1:0]    m_sel;
  logic [N-1:0]      m_cyc, m_stb, m_we;
  logic [DW-1:0]     m_dat_o;
  logic [N-1:0]      m_ack_o;
  logic [31:0]       s_adr_o;
  logic [2:0]        s_cti_o;
  logic [DW-1:0]     s_dat_o;
  logic [7:0]        s_sel_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [DW-1:0]     s_dat;
  logic              s_ack;
  logic [N-1:0]      grant_o;

  int checks = 0;
  int errors = 0;

  // Model state: granted port (-1 when idle), round-robin pointer, ack count.
  int mg, mptr, mcnt;
  int ng, nptr, ncnt;

  hpdmc_arb #(.NPORTS(N), .DW(DW), .MAXBURST(MB)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .m_adr_i   (m_adr),
    .m_cti_i   (m_cti),
    .m_dat_i   (m_dat),
    .m_sel_i   (m_sel),
    .m_cyc_i   (m_cyc),
    .m_stb_i   (m_stb),
    .m_we_i    (m_we),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .s_adr_o   (s_adr_o),
    .s_cti_o   (s_cti_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_dat_i   (s_dat),
    .s_ack_i   (s_ack),
    .grant_o   (grant_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mg = -1; mptr = 0; mcnt = 0;
  endtask

  task automatic rand_data();
    for (int k = 0; k < N; k++) begin
      m_adr[k*32 +: 32] = $urandom;
      m_dat[k*DW +: DW] = {$urandom, $urandom};
      m_sel[k*8 +: 8]   = 8'($urandom);
    end
    m_we  = N'($urandom);
    s_dat = {$urandom, $urandom};
  endtask

  // Compare DUT outputs with the model for the current cycle and work out the next model state.
  task automatic model_eval();
    logic [N-1:0] eg;
    logic [2:0]   cti_g;
    int           c;
    eg = (mg < 0) ? '0 : N'(1 << mg);
    chk("grant", 64'(grant_o), 64'(eg));
    chk("s_cyc", 64'(s_cyc_o), 64'((mg >= 0) ? m_cyc[mg] : 1'b0));
    chk("s_stb", 64'(s_stb_o), 64'((mg >= 0) ? m_stb[mg] : 1'b0));
    chk("m_ack", 64'(m_ack_o), 64'(s_ack ? eg : '0));
    chk("m_dat", m_dat_o, s_dat);
    ng = mg; nptr = mptr; ncnt = mcnt;
    if (mg < 0) begin
      for (int i = 0; i < N; i++) begin
        int p;
        p = (mptr + i) % N;
        if (m_cyc[p] && ng < 0) ng = p;
      end
      ncnt = 0;
    end else begin
      cti_g = m_cti[mg*3 +: 3];
      chk("s_adr", 64'(s_adr_o), 64'(m_adr[mg*32 +: 32]));
      chk("s_cti", 64'(s_cti_o), 64'(cti_g));
      chk("s_dat", s_dat_o, m_dat[mg*DW +: DW]);
      chk("s_sel", 64'(s_sel_o), 64'(m_sel[mg*8 +: 8]));
      chk("s_we", 64'(s_we_o), 64'(m_we[mg]));
      c = mcnt;
      if (s_ack && c < MB) c++;
      ncnt = c;
      if (!m_cyc[mg] ||
          (s_ack && c >= MB && (cti_g == 3'd0 || cti_g == 3'd7) && ((m_cyc & ~eg) != '0))) begin
        ng = -1;
        nptr = (mg + 1) % N;
      end
    end
  endtask

  // Called mid-cycle; returns 1 time unit after the next rising edge.
  task automatic step();
    #2;
    model_eval();
    @(posedge sys_clk);
    #1;
    mg = ng; mptr = nptr; mcnt = ncnt;
  endtask

  task automatic set_req(input logic [N-1:0] req);
    m_cyc = req;
    m_stb = req;
  endtask

  initial begin
    logic [2:0] cti_tab [4];
    cti_tab[0] = 3'd0; cti_tab[1] = 3'd1; cti_tab[2] = 3'd2; cti_tab[3] = 3'd7;

    sys_rst_n = 1'b0;
    m_cti = '0;
    set_req('1);
    s_ack = 1'b1;
    rand_data();
    model_reset();
    repeat (3) @(posedge sys_clk);
    #3;
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
    chk("rst_m_ack", 64'(m_ack_o), 64'd0);
    set_req('0);
    s_ack = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // Simultaneous requests from ports 1 and 3 right after reset.
    rand_data();
    set_req(4'b1010);
    step();
    chk("d024_grant", 64'(grant_o), 64'b0010);
    chk("d024_s_cyc", 64'(s_cyc_o), 64'd1);
    chk("d024_s_adr", 64'(s_adr_o), 64'(m_adr[63:32]));

    // Port 1 releases while port 3 waits.
    set_req(4'b1000);
    step();
    chk("d025_idle", 64'(s_cyc_o), 64'd0);
    step();
    chk("d025_grant", 64'(grant_o), 64'b1000);
    set_req('0);
    step();
    step();

    // Back-to-back classic reads from port 0 with port 2 waiting.
    rand_data();
    m_cti = '0;
    set_req(4'b0101);
    step();
    chk("d026_grant0", 64'(grant_o), 64'b0001);
    s_ack = 1'b1;
    repeat (3) begin
      step();
      chk("d026_hold", 64'(grant_o), 64'b0001);
    end
    step();
    chk("d026_idle", 64'(grant_o), 64'd0);
    chk("d026_idle_cyc", 64'(s_cyc_o), 64'd0);
    step();
    chk("d026_grant2", 64'(grant_o), 64'b0100);
    s_ack = 1'b0;
    set_req(4'b0001);
    step();
    step();
    chk("d026_regain", 64'(grant_o), 64'b0001);
    set_req('0);
    step();
    step();

    // Single requester is never preempted.
    rand_data();
    set_req(4'b0100);
    s_ack = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("d028_grant", 64'(grant_o), 64'b0100);
      chk("d028_other_ack", 64'(m_ack_o & 4'b1011), 64'd0);
    end
    s_ack = 1'b0;
    set_req('0);
    step();
    step();

    // Incrementing burst is never split even past MAXBURST acks.
    rand_data();
    m_cti = {4{3'b010}};
    set_req(4'b0001);
    step();
    set_req(4'b0011);
    s_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("d027_hold", 64'(grant_o), 64'b0001);
    end
    m_cti[2:0] = 3'b111;
    step();
    chk("d027_idle", 64'(s_cyc_o), 64'd0);
    step();
    chk("d027_grant1", 64'(grant_o), 64'b0010);
    s_ack = 1'b0;
    set_req('0);
    step();
    step();

    // Random traffic with sticky cycles so bursts and preemption both occur.
    for (int n = 0; n < 3000; n++) begin
      rand_data();
      for (int k = 0; k < N; k++) begin
        if (m_cyc[k]) m_cyc[k] = ($urandom_range(99) >= 8);
        else          m_cyc[k] = ($urandom_range(99) < 15);
        m_stb[k] = m_cyc[k] && ($urandom_range(99) < 80);
        m_cti[k*3 +: 3] = cti_tab[$urandom_range(3)];
      end
      s_ack = ($urandom_range(1) == 1);
      step();
    end
    set_req('0);
    s_ack = 1'b0;
    step();
    step();

    // Reset pulse in the middle of a port 3 burst.
    m_cti = {4{3'b010}};
    set_req(4'b1000);
    step();
    chk("d029_grant3", 64'(grant_o), 64'b1000);
    s_ack = 1'b1;
    step();
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("d029_rst_cyc", 64'(s_cyc_o), 64'd0);
    chk("d029_rst_grant", 64'(grant_o), 64'd0);
    chk("d029_rst_ack", 64'(m_ack_o), 64'd0);
    model_reset();
    s_ack = 1'b0;
    set_req('1);
    #2;
    sys_rst_n = 1'b1;
    step();
    chk("d029_grant0", 64'(grant_o), 64'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
